// File: rtl/bmp180_conv_sched_pkg.sv
// BMP180 conversion scheduler: shared states, sensor constants
// and conversion-time helpers.
package bmp180_conv_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T_CMD,
    S_T_WAIT,
    S_T_READ,
    S_P_CMD,
    S_P_WAIT,
    S_P_READ,
    S_FIN
  } state_t;

  localparam logic [7:0] REG_CTRL = 8'hF4;
  localparam logic [7:0] REG_DATA = 8'hF6;
  localparam logic [7:0] CMD_TEMP = 8'h2E;
  localparam logic [7:0] CMD_PRES = 8'h34;

  localparam logic [1:0] RD_LEN_T = 2'd2;
  localparam logic [1:0] RD_LEN_P = 2'd3;

  // Conversion times in units of 100 us
  localparam int unsigned T_CONV_T  = 45;
  localparam int unsigned T_CONV_P0 = 45;
  localparam int unsigned T_CONV_P1 = 75;
  localparam int unsigned T_CONV_P2 = 135;
  localparam int unsigned T_CONV_P3 = 255;

  function automatic longint unsigned conv_cycles(
    input longint unsigned fclk,
    input int unsigned     t100us
  );
    return (fclk * longint'(t100us)) / 64'd10000;
  endfunction

  function automatic logic [7:0] pres_cmd(
    input logic [1:0] oss
  );
    return CMD_PRES | {oss, 6'b00_0000};
  endfunction

endpackage

// File: rtl/bmp180_conv_sched_conv_wait_timer.sv
// Conversion wait counter: counts cycles while enabled,
// flags the last cycle of the terminal count.
module bmp180_conv_sched_conv_wait_timer #(
  parameter int unsigned W = 21
) (
  input  logic         CLK,
  input  logic         RST_n,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_tc,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_last;

  assign w_last    = i_tc - W'(1);
  assign o_expired = i_en && (r_cnt >= w_last);

  // Back to zero on expiry so the count reads 0 outside wait
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_expired) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/bmp180_conv_sched.sv
// BMP180 scheduler: temperature then pressure conversion,
// each a ctrl write, a timed wait and a data burst read.
module bmp180_conv_sched
  import bmp180_conv_sched_pkg::*;
#(
  parameter int unsigned FPGA_CLK = 50_000_000
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       I_START,
  input  logic [1:0] I_OSS,
  input  logic       I_I2C_DONE,
  input  logic       I_I2C_ERR,
  output logic       O_WR_REQ,
  output logic [7:0] O_CTRL_BYTE,
  output logic       O_RD_REQ,
  output logic [1:0] O_RD_LEN,
  output logic       O_PHASE,
  output logic       O_BUSY,
  output logic       O_DONE,
  output logic       O_ERR
);

  localparam longint unsigned FCLK = 64'(FPGA_CLK);

  localparam int unsigned N_T  =
    32'(conv_cycles(FCLK, T_CONV_T));
  localparam int unsigned N_P0 =
    32'(conv_cycles(FCLK, T_CONV_P0));
  localparam int unsigned N_P1 =
    32'(conv_cycles(FCLK, T_CONV_P1));
  localparam int unsigned N_P2 =
    32'(conv_cycles(FCLK, T_CONV_P2));
  localparam int unsigned N_P3 =
    32'(conv_cycles(FCLK, T_CONV_P3));

  localparam int unsigned CNT_SZ = $clog2(N_P3);

  state_t           r_state;
  logic [1:0]       r_oss;
  logic             r_wr;
  logic [7:0]       r_ctrl;
  logic             r_rd;
  logic [1:0]       r_len;
  logic             r_phase;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_wait;
  logic             w_xfer;
  logic             w_abort;
  logic             w_expired;
  logic [CNT_SZ-1:0] w_tc;

  assign w_wait = (r_state == S_T_WAIT) ||
                  (r_state == S_P_WAIT);

  assign w_xfer = (r_state == S_T_CMD)  ||
                  (r_state == S_T_READ) ||
                  (r_state == S_P_CMD)  ||
                  (r_state == S_P_READ);

  assign w_abort = w_xfer && I_I2C_ERR;

  // Pressure wait always follows the OSS latched at start
  always_comb begin
    w_tc = CNT_SZ'(N_T);
    if (r_state == S_P_WAIT) begin
      unique case (r_oss)
        2'd0: w_tc = CNT_SZ'(N_P0);
        2'd1: w_tc = CNT_SZ'(N_P1);
        2'd2: w_tc = CNT_SZ'(N_P2);
        2'd3: w_tc = CNT_SZ'(N_P3);
      endcase
    end
  end

  bmp180_conv_sched_conv_wait_timer #(
    .W (CNT_SZ)
  ) u_timer (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .i_clear   (~w_wait),
    .i_en      (w_wait),
    .i_tc      (w_tc),
    .o_expired (w_expired)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= S_IDLE;
      r_oss   <= 2'd0;
      r_wr    <= 1'b0;
      r_ctrl  <= 8'h00;
      r_rd    <= 1'b0;
      r_len   <= 2'd0;
      r_phase <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_abort) begin
        r_state <= S_IDLE;
        r_wr    <= 1'b0;
        r_ctrl  <= 8'h00;
        r_rd    <= 1'b0;
        r_len   <= 2'd0;
        r_phase <= 1'b0;
        r_busy  <= 1'b0;
        r_err   <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (I_START) begin
              r_oss   <= I_OSS;
              r_state <= S_T_CMD;
              r_busy  <= 1'b1;
              r_wr    <= 1'b1;
              r_ctrl  <= CMD_TEMP;
            end
          end
          S_T_CMD: begin
            if (I_I2C_DONE) begin
              r_state <= S_T_WAIT;
              r_wr    <= 1'b0;
              r_ctrl  <= 8'h00;
            end
          end
          S_T_WAIT: begin
            if (w_expired) begin
              r_state <= S_T_READ;
              r_rd    <= 1'b1;
              r_len   <= RD_LEN_T;
            end
          end
          S_T_READ: begin
            if (I_I2C_DONE) begin
              r_state <= S_P_CMD;
              r_rd    <= 1'b0;
              r_len   <= 2'd0;
              r_wr    <= 1'b1;
              r_ctrl  <= pres_cmd(r_oss);
              r_phase <= 1'b1;
            end
          end
          S_P_CMD: begin
            if (I_I2C_DONE) begin
              r_state <= S_P_WAIT;
              r_wr    <= 1'b0;
              r_ctrl  <= 8'h00;
            end
          end
          S_P_WAIT: begin
            if (w_expired) begin
              r_state <= S_P_READ;
              r_rd    <= 1'b1;
              r_len   <= RD_LEN_P;
            end
          end
          S_P_READ: begin
            if (I_I2C_DONE) begin
              r_state <= S_FIN;
              r_rd    <= 1'b0;
              r_len   <= 2'd0;
              r_done  <= 1'b1;
            end
          end
          S_FIN: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_phase <= 1'b0;
          end
        endcase
      end
    end
  end

  assign O_WR_REQ    = r_wr;
  assign O_CTRL_BYTE = r_ctrl;
  assign O_RD_REQ    = r_rd;
  assign O_RD_LEN    = r_len;
  assign O_PHASE     = r_phase;
  assign O_BUSY      = r_busy;
  assign O_DONE      = r_done;
  assign O_ERR       = r_err;

endmodule

// File: tb/tb_bmp180_conv_sched.sv
// Bench for bmp180_conv_sched: sequence-level model, bus
// responder, cycle compare and directed literal checks.
module tb_bmp180_conv_sched;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       I_START = 1'b0;
  logic [1:0] I_OSS = 2'd0;
  logic       I_I2C_DONE;
  logic       I_I2C_ERR;
  logic       O_WR_REQ;
  logic [7:0] O_CTRL_BYTE;
  logic       O_RD_REQ;
  logic [1:0] O_RD_LEN;
  logic       O_PHASE;
  logic       O_BUSY;
  logic       O_DONE;
  logic       O_ERR;

  logic bus_done = 1'b0;
  logic bus_err  = 1'b0;
  logic man_done = 1'b0;
  logic man_err  = 1'b0;

  assign I_I2C_DONE = bus_done | man_done;
  assign I_I2C_ERR  = bus_err | man_err;

  int total = 0;
  int bad   = 0;

  bmp180_conv_sched #(
    .FPGA_CLK (1_000_000)
  ) dut (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .I_START     (I_START),
    .I_OSS       (I_OSS),
    .I_I2C_DONE  (I_I2C_DONE),
    .I_I2C_ERR   (I_I2C_ERR),
    .O_WR_REQ    (O_WR_REQ),
    .O_CTRL_BYTE (O_CTRL_BYTE),
    .O_RD_REQ    (O_RD_REQ),
    .O_RD_LEN    (O_RD_LEN),
    .O_PHASE     (O_PHASE),
    .O_BUSY      (O_BUSY),
    .O_DONE      (O_DONE),
    .O_ERR       (O_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Sequence model: step 0 idle, 1 write T, 2 wait T, 3 read T,
  // 4 write P, 5 wait P, 6 read P, 7 finish.
  localparam int NT = 4500;
  int np [4] = '{4500, 7500, 13500, 25500};

  int         m_step;
  int         m_wait;
  logic [1:0] m_oss;
  logic       m_err;

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      m_step = 0;
      m_wait = 0;
      m_oss  = 2'd0;
      m_err  = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_step == 0) begin
        if (I_START) begin
          m_oss  = I_OSS;
          m_step = 1;
        end
      end else if (m_step == 2 || m_step == 5) begin
        m_wait++;
        if (m_wait == ((m_step == 2) ? NT : np[m_oss])) begin
          m_wait = 0;
          m_step++;
        end
      end else if (m_step == 7) begin
        m_step = 0;
      end else if (I_I2C_ERR) begin
        m_step = 0;
        m_err  = 1'b1;
      end else if (I_I2C_DONE) begin
        m_step++;
      end
    end
  end

  function automatic logic [15:0] m_expect();
    logic       wr, rd, ph;
    logic [7:0] cb;
    logic [1:0] ln;
    wr = (m_step == 1) || (m_step == 4);
    rd = (m_step == 3) || (m_step == 6);
    cb = (m_step == 1) ? 8'h2E :
         (m_step == 4) ? (8'h34 + 8'(m_oss) * 8'd64) : 8'h00;
    ln = (m_step == 3) ? 2'd2 : (m_step == 6) ? 2'd3 : 2'd0;
    ph = (m_step >= 4);
    return {m_step != 0, wr, cb, rd, ln, ph,
            m_step == 7, m_err};
  endfunction

  always @(negedge CLK) begin
    chk("cycle", {O_BUSY, O_WR_REQ, O_CTRL_BYTE, O_RD_REQ,
                  O_RD_LEN, O_PHASE, O_DONE, O_ERR},
        m_expect());
  end

  // Observation of the run for literal checks
  int         waitc [2];
  logic [7:0] wrb [4];
  logic [1:0] rdl [4];
  int         nwr, nrd, ndone, nerr;
  logic       p_wr = 1'b0;
  logic       p_rd = 1'b0;

  always @(negedge CLK) begin
    if (O_BUSY && !O_WR_REQ && !O_RD_REQ && !O_DONE)
      waitc[O_PHASE]++;
    if (O_WR_REQ && !p_wr && nwr < 4) begin
      wrb[nwr] = O_CTRL_BYTE;
      nwr++;
    end
    if (O_RD_REQ && !p_rd && nrd < 4) begin
      rdl[nrd] = O_RD_LEN;
      nrd++;
    end
    if (O_DONE) ndone++;
    if (O_ERR) nerr++;
    p_wr = O_WR_REQ;
    p_rd = O_RD_REQ;
  end

  // I2C master stand-in: answers each request after 10 cycles
  int req_idx  = 0;
  int err_idx  = -1;
  int both_idx = -1;

  always begin
    @(negedge CLK);
    if (RST_n && (O_WR_REQ || O_RD_REQ)) begin
      repeat (10) @(negedge CLK);
      @(posedge CLK);
      #1;
      if (req_idx == err_idx) begin
        bus_err = 1'b1;
      end else if (req_idx == both_idx) begin
        bus_err  = 1'b1;
        bus_done = 1'b1;
      end else begin
        bus_done = 1'b1;
      end
      @(posedge CLK);
      #1;
      bus_done = 1'b0;
      bus_err  = 1'b0;
      req_idx++;
    end
  end

  task automatic clear_obs(input int e_idx, input int b_idx);
    waitc[0] = 0;
    waitc[1] = 0;
    nwr = 0;
    nrd = 0;
    ndone = 0;
    nerr = 0;
    req_idx = 0;
    err_idx = e_idx;
    both_idx = b_idx;
  endtask

  task automatic start_pulse(input logic [1:0] oss);
    @(posedge CLK);
    #1;
    I_OSS   = oss;
    I_START = 1'b1;
    @(posedge CLK);
    #1;
    I_START = 1'b0;
    I_OSS   = ~oss;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (n < 40000) begin
      @(negedge CLK);
      if (!O_BUSY) break;
      n++;
    end
    if (n >= 40000) chk({nm, "_timeout"}, 32'd1, 32'd0);
    @(posedge CLK);
    #1;
  endtask

  localparam logic [7:0] PCMD [3] = '{8'h34, 8'h74, 8'hB4};

  initial begin
    // Reset held: everything low
    clear_obs(-1, -1);
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_outs", {O_BUSY, O_WR_REQ, O_CTRL_BYTE, O_RD_REQ,
                     O_RD_LEN, O_PHASE, O_DONE, O_ERR}, 32'd0);
    RST_n = 1'b1;
    @(posedge CLK);
    #1;
    man_done = 1'b1;
    @(posedge CLK);
    #1;
    man_done = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    chk("idle_busy", 32'(ndone + nerr + nwr), 32'd0);

    // Full sequence at OSS 3 with stray START/DONE in T_WAIT
    clear_obs(-1, -1);
    start_pulse(2'd3);
    repeat (100) @(posedge CLK);
    #1;
    man_done = 1'b1;
    I_START  = 1'b1;
    @(posedge CLK);
    #1;
    man_done = 1'b0;
    I_START  = 1'b0;
    wait_idle("s2");
    chk("s2_twait", 32'(waitc[0]), 32'd4500);
    chk("s2_pwait", 32'(waitc[1]), 32'd25500);
    chk("s2_nwr", 32'(nwr), 32'd2);
    chk("s2_nrd", 32'(nrd), 32'd2);
    chk("s2_wr0", 32'(wrb[0]), 32'h2E);
    chk("s2_wr1", 32'(wrb[1]), 32'hF4);
    chk("s2_rd0", 32'(rdl[0]), 32'd2);
    chk("s2_rd1", 32'(rdl[1]), 32'd3);
    chk("s2_done", 32'(ndone), 32'd1);
    chk("s2_err", 32'(nerr), 32'd0);
    repeat (20) @(posedge CLK);
    #1;
    chk("s2_nostart", 32'(nwr), 32'd2);

    // Bus error while reading pressure
    clear_obs(3, -1);
    start_pulse(2'd0);
    wait_idle("s4");
    chk("s4_err", 32'(nerr), 32'd1);
    chk("s4_done", 32'(ndone), 32'd0);
    chk("s4_pwait", 32'(waitc[1]), 32'd4500);

    // DONE and ERR together on the temperature write
    clear_obs(-1, 0);
    start_pulse(2'd1);
    wait_idle("s5");
    chk("s5_err", 32'(nerr), 32'd1);
    chk("s5_done", 32'(ndone), 32'd0);
    chk("s5_twait", 32'(waitc[0]), 32'd0);

    // Reset in the middle of the pressure wait
    clear_obs(-1, -1);
    start_pulse(2'd0);
    begin
      int n;
      n = 0;
      while (n < 6000) begin
        @(negedge CLK);
        if (O_BUSY && O_PHASE && !O_WR_REQ && !O_RD_REQ)
          break;
        n++;
      end
      if (n >= 6000) chk("s6_timeout", 32'd1, 32'd0);
    end
    repeat (50) @(posedge CLK);
    #3;
    RST_n = 1'b0;
    #1;
    chk("s6_async", {O_BUSY, O_WR_REQ, O_CTRL_BYTE, O_RD_REQ,
                     O_RD_LEN, O_PHASE, O_DONE, O_ERR}, 32'd0);
    repeat (2) @(posedge CLK);
    #3;
    RST_n = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    chk("s6_nopulse", 32'(ndone + nerr), 32'd0);

    // OSS sweep, live OSS scrambled after start
    for (int k = 0; k < 3; k++) begin
      clear_obs(-1, -1);
      start_pulse(2'(k));
      wait_idle("s3");
      chk($sformatf("s3_pwait%0d", k), 32'(waitc[1]),
          32'(np[k]));
      chk($sformatf("s3_pcmd%0d", k), 32'(wrb[1]),
          32'(PCMD[k]));
      chk($sformatf("s3_done%0d", k), 32'(ndone), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
